// File: rtl/shift_deserializer8_pkg.sv
// Shared types and constants for the serial-to-parallel word assembler.
package shift_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam logic DIR_MSB_FIRST = 1'b0;
  localparam logic DIR_LSB_FIRST = 1'b1;

  localparam int WIDTH_DEFAULT = 8;

endpackage

// File: rtl/shift_deserializer8_if.sv
// Serial input / parallel output bundle between a bit source and the deserializer.
interface shift_deserializer8_if
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) ();

  logic             sin;
  logic             sin_valid;
  logic             sof;
  logic             dir;
  logic             par_ready;
  logic             clr_ovr;
  logic [WIDTH-1:0] par_out;
  logic             par_valid;
  logic             overrun;
  logic             busy;

  modport master (
    output sin, sin_valid, sof, dir, par_ready, clr_ovr,
    input  par_out, par_valid, overrun, busy
  );

  modport slave (
    input  sin, sin_valid, sof, dir, par_ready, clr_ovr,
    output par_out, par_valid, overrun, busy
  );

endinterface

// File: rtl/shift_deserializer8.sv
// Falling-edge serial-to-parallel deserializer with a one-word output register,
// selectable bit order, start-of-frame resync and a sticky overrun flag.
module shift_deserializer8
  import shift_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst_n,
  shift_deserializer8_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
    $error("shift_deserializer8: WIDTH must be in 2..32");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_base;
  logic [WIDTH-1:0] shift_q, shift_d, base, word;
  logic [WIDTH-1:0] par_out_q, par_out_d;
  logic             dir_q, dir_d;
  logic             par_valid_q, par_valid_d;
  logic             overrun_q, overrun_d;
  logic             start_new, dir_eff, complete, ovr_evt;

  // A bit arriving in IDLE or together with sof starts a fresh word from an empty shifter.
  always_comb begin
    start_new = bus.sof || (state_q == IDLE);
    dir_eff   = start_new ? bus.dir : dir_q;
    base      = start_new ? '0 : shift_q;
    cnt_base  = start_new ? '0 : cnt_q;
    word      = (dir_eff == DIR_MSB_FIRST) ? {base[WIDTH-2:0], bus.sin}
                                           : {bus.sin, base[WIDTH-1:1]};
    complete  = bus.sin_valid && (cnt_base == CNT_W'(WIDTH - 1));
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    dir_d       = dir_q;
    par_out_d   = par_out_q;
    par_valid_d = par_valid_q;
    overrun_d   = overrun_q;
    ovr_evt     = 1'b0;

    if (bus.sin_valid) begin
      dir_d = dir_eff;
      if (complete) begin
        state_d = IDLE;
        cnt_d   = '0;
        shift_d = '0;
      end else begin
        state_d = SHIFT;
        cnt_d   = cnt_base + CNT_W'(1);
        shift_d = word;
      end
    end else if (bus.sof) begin
      state_d = IDLE;
      cnt_d   = '0;
      shift_d = '0;
    end

    if (par_valid_q && bus.par_ready) begin
      par_valid_d = 1'b0;
    end

    // The output register only takes a new word once the old one is gone or leaving now.
    if (complete) begin
      if (!par_valid_q || bus.par_ready) begin
        par_out_d   = word;
        par_valid_d = 1'b1;
      end else begin
        ovr_evt = 1'b1;
      end
    end

    if (ovr_evt) begin
      overrun_d = 1'b1;
    end else if (bus.clr_ovr) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      dir_q       <= DIR_MSB_FIRST;
      par_out_q   <= '0;
      par_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      shift_q     <= shift_d;
      dir_q       <= dir_d;
      par_out_q   <= par_out_d;
      par_valid_q <= par_valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign bus.par_out   = par_out_q;
  assign bus.par_valid = par_valid_q;
  assign bus.overrun   = overrun_q;
  assign bus.busy      = (state_q == SHIFT);

endmodule

// File: tb/tb_shift_deserializer8.sv
// Scoreboard bench: a bit-list reference model predicts words, a monitor checks par_out.
module tb_shift_deserializer8;
  import shift_pkg::*;

  localparam int WIDTH = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   tests = 0;
  int   fails = 0;

  bit               mBits[$];
  logic [WIDTH-1:0] expQ[$];
  bit               mDir;
  bit               mValid;
  bit               mOvr;

  shift_deserializer8_if #(.WIDTH(WIDTH)) bus ();

  shift_deserializer8 #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word value from the collected bit list, first bit landing at MSB or LSB.
  function automatic logic [WIDTH-1:0] assemble(input bit lsbFirst);
    logic [WIDTH-1:0] w = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (lsbFirst) w[i] = mBits[i];
      else          w[WIDTH-1-i] = mBits[i];
    end
    return w;
  endfunction

  task automatic modelStep(input bit s, input bit sv, input bit sf, input bit d,
                           input bit rdy, input bit clr);
    bit consumed = mValid && rdy;
    bit loaded   = 1'b0;
    bit ovrEvt   = 1'b0;
    if (sf) mBits.delete();
    if (sv) begin
      if (mBits.size() == 0) mDir = d;
      mBits.push_back(s);
      if (mBits.size() == WIDTH) begin
        logic [WIDTH-1:0] w = assemble(mDir);
        mBits.delete();
        if (!mValid || rdy) begin
          expQ.push_back(w);
          loaded = 1'b1;
        end else begin
          ovrEvt = 1'b1;
        end
      end
    end
    mValid = loaded ? 1'b1 : (consumed ? 1'b0 : mValid);
    mOvr   = ovrEvt ? 1'b1 : (clr ? 1'b0 : mOvr);
  endtask

  task automatic checkState();
    checkOutput("busy", {31'b0, bus.busy}, {31'b0, mBits.size() != 0});
    checkOutput("overrun", {31'b0, bus.overrun}, {31'b0, mOvr});
    checkOutput("par_valid", {31'b0, bus.par_valid}, {31'b0, mValid});
  endtask

  // Drive one edge worth of inputs, advance the model, then check after the falling edge.
  task automatic applyStimulus(input bit s, input bit sv, input bit sf, input bit d,
                               input bit rdy, input bit clr);
    bus.sin       = s;
    bus.sin_valid = sv;
    bus.sof       = sf;
    bus.dir       = d;
    bus.par_ready = rdy;
    bus.clr_ovr   = clr;
    modelStep(s, sv, sf, d, rdy, clr);
    @(negedge clk);
    #1;
    checkState();
  endtask

  task automatic sendWord(input logic [WIDTH-1:0] w, input bit d, input bit rdyMid, input bit rdyLast);
    for (int i = 0; i < WIDTH; i++) begin
      bit b = d ? w[i] : w[WIDTH-1-i];
      applyStimulus(b, 1'b1, 1'b0, d, (i == WIDTH-1) ? rdyLast : rdyMid, 1'b0);
    end
  endtask

  task automatic doReset();
    #1 rst_n = 1'b0;
    mBits.delete();
    expQ.delete();
    mDir   = 1'b0;
    mValid = 1'b0;
    mOvr   = 1'b0;
    #1;
    checkOutput("rst_par_out", {24'b0, bus.par_out}, 32'h0);
    checkOutput("rst_par_valid", {31'b0, bus.par_valid}, 32'h0);
    checkOutput("rst_overrun", {31'b0, bus.overrun}, 32'h0);
    checkOutput("rst_busy", {31'b0, bus.busy}, 32'h0);
    rst_n = 1'b1;
  endtask

  // Monitor: every presented word must match the oldest predicted one; pop on consume.
  always @(posedge clk) begin
    if (rst_n && bus.par_valid) begin
      if (expQ.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL scoreboard: got word %0h expected none at %0t", bus.par_out, $time);
      end else begin
        checkOutput("par_out", {24'b0, bus.par_out}, {24'b0, expQ[0]});
        if (bus.par_ready) void'(expQ.pop_front());
      end
    end
  end

  initial begin
    bit curDir = 1'b0;
    rst_n         = 1'b0;
    bus.sin       = 1'b0;
    bus.sin_valid = 1'b0;
    bus.sof       = 1'b0;
    bus.dir       = 1'b0;
    bus.par_ready = 1'b0;
    bus.clr_ovr   = 1'b0;
    mDir = 1'b0; mValid = 1'b0; mOvr = 1'b0;
    #1;
    checkOutput("init_par_out", {24'b0, bus.par_out}, 32'h0);
    checkState();
    @(negedge clk);
    #1 rst_n = 1'b1;

    sendWord(8'hAB, DIR_MSB_FIRST, 1'b1, 1'b1);
    checkOutput("msb_word", {24'b0, bus.par_out}, 32'hAB);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    sendWord(8'hD5, DIR_LSB_FIRST, 1'b1, 1'b1);
    checkOutput("lsb_word", {24'b0, bus.par_out}, 32'hD5);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    sendWord(8'hAB, DIR_MSB_FIRST, 1'b0, 1'b0);
    sendWord(8'h3C, DIR_MSB_FIRST, 1'b0, 1'b0);
    checkOutput("ovr_hold", {24'b0, bus.par_out}, 32'hAB);
    checkOutput("ovr_set", {31'b0, bus.overrun}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    for (int i = 6; i >= 0; i--) begin
      logic [7:0] v = 8'h5A;
      applyStimulus(v[i], 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    end
    checkOutput("sof_word", {24'b0, bus.par_out}, 32'h5A);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    doReset();
    sendWord(8'hF0, DIR_MSB_FIRST, 1'b1, 1'b1);
    checkOutput("post_rst_word", {24'b0, bus.par_out}, 32'hF0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    sendWord(8'hAB, DIR_MSB_FIRST, 1'b0, 1'b0);
    sendWord(8'h81, DIR_MSB_FIRST, 1'b0, 1'b1);
    checkOutput("b2b_word", {24'b0, bus.par_out}, 32'h81);
    checkOutput("b2b_valid", {31'b0, bus.par_valid}, 32'h1);
    checkOutput("b2b_no_ovr", {31'b0, bus.overrun}, 32'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      if ($urandom_range(0, 9) == 0) curDir = ~curDir;
      applyStimulus(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                    $urandom_range(0, 24) == 0, curDir,
                    $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
    end

    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 1'b0, curDir, 1'b1, 1'b0);
    checkOutput("queue_drained", expQ.size(), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/shift_deserializer8.md
SHIFT_DESERIALIZER8 -- requirements
Module: shift_deserializer8

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning bits per word; legal range 2..32.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on falling edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sin  input  1  serial data bit.
REQ-005 SHALL have port sin_valid  input  1  sin carries a valid bit this edge.
REQ-006 SHALL have port sof  input  1  start-of-frame; resynchronises the bit counter.
REQ-007 SHALL have port dir  input  1  arrival order; 0 = MSB first, 1 = LSB first.
REQ-008 SHALL have port par_ready  input  1  consumer accepts par_out this edge.
REQ-009 SHALL have port clr_ovr  input  1  clears the sticky overrun flag.
REQ-010 SHALL have port par_out  output  WIDTH  assembled word.
REQ-011 SHALL have port par_valid  output  1  par_out holds an unconsumed word.
REQ-012 SHALL have port overrun  output  1  sticky flag: a completed word was dropped.
REQ-013 SHALL have port busy  output  1  a partial word is in progress (state SHIFT).

Function
REQ-014 SHALL implement states IDLE (0 bits collected) and SHIFT (1..WIDTH-1 bits collected), with a bit counter of width clog2(WIDTH).
REQ-015 SHALL sample sin only on falling edges with sin_valid=1; edges with sin_valid=0 SHALL hold shifter, counter and state.
REQ-016 SHALL latch dir on the first bit of each word; a dir change mid-word SHALL take effect at the next word.
REQ-017 dir=0: SHALL shift left, inserting sin at bit 0; dir=1: SHALL shift right, inserting sin at bit WIDTH-1.
REQ-018 On the edge sampling the WIDTH-th bit, SHALL load the complete word into par_out, set par_valid, clear the counter and return to IDLE (zero extra latency).
REQ-019 A word SHALL be consumed on a falling edge with par_valid=1 and par_ready=1; par_valid SHALL then clear unless a new word completes on that same edge, in which case the new word loads and par_valid stays 1.
REQ-020 If a word completes while par_valid=1 and par_ready=0, SHALL keep the old par_out, discard the new word and set overrun.
REQ-021 overrun SHALL remain set until an edge with clr_ovr=1; if clr_ovr and a new overrun event occur on the same edge, overrun SHALL stay 1.
REQ-022 sof=1 with sin_valid=1 SHALL discard any partial word and treat sin as bit 1 of a new word, latching dir.
REQ-023 sof=1 with sin_valid=0 SHALL discard any partial word and go to IDLE.
REQ-024 par_out SHALL remain stable while par_valid=1 and not consumed.
REQ-025 busy SHALL equal 1 exactly in state SHIFT.

Reset
REQ-026 rst_n=0 SHALL immediately force state IDLE, counter 0, shifter 0, par_out 0, par_valid 0, overrun 0, busy 0, latched dir 0.
REQ-027 Reset mid-word SHALL discard the partial word; the first valid bit after release SHALL be bit 1 of a new word.

Structure
REQ-028 Package shift_pkg SHALL hold the state enum (IDLE, SHIFT), dir encodings (DIR_MSB_FIRST=0, DIR_LSB_FIRST=1) and WIDTH default 8.
REQ-029 SHALL be a single module; no sub-module is required.

Verification
REQ-030 dir=0, bits 1,0,1,0,1,0,1,1, par_ready=1 -> par_out=8'hAB, par_valid high for one edge.
REQ-031 dir=1, same bit sequence -> par_out=8'hD5.
REQ-032 par_ready=0, send 8'hAB then 8'h3C -> par_out stays 8'hAB, overrun=1; clr_ovr pulse -> overrun=0.
REQ-033 Send 3 bits, then sof=1 with sin_valid=1, then 7 more bits of 8'h5A MSB-first -> par_out=8'h5A, partial discarded.
REQ-034 Send 5 bits, pulse rst_n=0 asynchronously between edges -> all outputs 0 immediately; next 8 bits of 8'hF0 -> par_out=8'hF0.
REQ-035 par_valid=1 with par_ready=1 on the edge a new word 8'h81 completes -> par_valid stays 1, par_out=8'h81, overrun=0.
